colocador_barcos: RTL
=====================

COLOCADOR_BARCOS -- requirements
Module: colocador_barcos

Interface
REQ-001 Parameter NUM_BARCOS, default 5, ship count; ship i has length i+1; legal range 1..5.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-004 start  in  1  begin or restart a placement session.
REQ-005 up / down / left / right  in  1 each  single-cycle cursor move pulses.
REQ-006 rotate  in  1  toggle orientation pulse; confirm  in  1  request placement of current ship.
REQ-007 cur_x, cur_y  out  3 each  cursor column and row, 0..4.
REQ-008 orient  out  1  0 = horizontal (+x), 1 = vertical (+y); barco_idx  out  3  ship being placed.
REQ-009 wr_en  out  1  one-cycle write strobe to the ship register; wr_barco  out  3, wr_pos  out  5, wr_orient  out  1  write payload.
REQ-010 err  out  1  one-cycle illegal-placement pulse; busy  out  1  session active; done  out  1  all ships placed.
REQ-011 ocupado  out  25  board occupancy map, bit = y*5+x.

Function
REQ-012 The FSM SHALL have states IDLE, PLACE, CHECK, WRITE, DONE.
REQ-013 IDLE->PLACE on start: cursor (0,0), orient 0, barco_idx 0, ocupado cleared.
REQ-014 In PLACE, the move pulses SHALL step the cursor by 1, saturating at 0 and 4; priority up>down>left>right when several pulses coincide; only one step per cycle.
REQ-015 In PLACE, rotate SHALL toggle orient; confirm SHALL move to CHECK and take priority over move and rotate in the same cycle, which are then ignored.
REQ-016 CHECK lasts exactly 1 cycle: legal if (orient=0: x+len-1<=4; orient=1: y+len-1<=4) and no overlap (see REQ-024).
REQ-017 Illegal: err=1 for one cycle, return to PLACE with cursor, orient and barco_idx unchanged.
REQ-018 Legal: WRITE for one cycle with wr_en=1, wr_barco=barco_idx, wr_pos=y*5+x, wr_orient=orient; ship cells ORed into ocupado in the same edge.
REQ-019 After WRITE: if barco_idx=NUM_BARCOS-1, go to DONE; else increment barco_idx, reset the cursor to (0,0) and orient to 0, and go to PLACE; confirm-to-wr_en latency is 2 cycles.
REQ-020 DONE: done=1 held; start SHALL restart as in REQ-013; moves and confirm are ignored.
REQ-021 start is ignored in PLACE, CHECK and WRITE.
REQ-022 busy=1 in PLACE, CHECK and WRITE, else 0; wr_en and err are never asserted together.

Reset
REQ-023 On rst=0: state IDLE, cur_x=cur_y=0, orient=0, barco_idx=0, ocupado=0, and wr_en, wr_barco, wr_pos, wr_orient, err, busy, done all 0; mid-session reset abandons the session with no write.

Configuration
REQ-024 Macro COLOCADOR_OVERLAP_CHK_EN: when defined, CHECK also requires (ship mask AND ocupado)=0; when undefined, only bounds are checked, ocupado is still maintained, and overlapping placements are accepted.

Structure
REQ-025 Package colocador_pkg SHALL hold BOARD_DIM=5, CELLS=25, the state enum type, and the ship-length function (idx+1).
REQ-026 Sub-module mascara_barco (combinational: x, y, orient, len -> 25-bit cell mask and in_bounds) SHALL be shared by CHECK and the ocupado update.

Verification
REQ-027 Reset, then start, confirm -> 2 cycles later wr_en=1, wr_barco=0, wr_pos=0, wr_orient=0; ocupado bit0=1.
REQ-028 Ship 1 (len 2): 4x right to (4,0), orient 0, confirm -> err pulse, no wr_en; rotate, confirm -> wr_pos=4, wr_orient=1, ocupado bits 4 and 9 set.
REQ-029 With overlap check: ship at (0,0), then next ship confirmed at (0,0) -> err=1; without the macro -> wr_en=1.
REQ-030 left at x=0 and up at y=0 -> cursor stays (0,0); up+right same cycle at (2,2) -> (2,1); confirm+right same cycle -> no cursor move, CHECK entered.
REQ-031 Five legal placements -> done=1 held, busy=0; start -> barco_idx=0, ocupado=0, busy=1.
REQ-032 rst low during CHECK -> all outputs 0 asynchronously, no wr_en after release.

Source files
------------

// File: rtl/colocador_pkg.sv
// colocador_pkg: shared board constants, FSM state type and ship-length helper
package colocador_pkg;
  localparam int BOARD_DIM = 5;
  localparam int CELLS = 25;
  typedef enum logic [2:0] {IDLE, PLACE, CHECK, WRITE, DONE} estado_t;
  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction
endpackage

// File: rtl/mascara_barco.sv
// mascara_barco: combinational cell mask and bounds test for one ship placement
module mascara_barco
  import colocador_pkg::*;
(
  input  logic [2:0]       x,
  input  logic [2:0]       y,
  input  logic             orient,
  input  logic [2:0]       len,
  output logic [CELLS-1:0] mask,
  output logic             in_bounds
);
  logic [3:0] xe, ye, le;
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign le = {1'b0, len};
  // start + len <= 5 is the same as the last cell landing on index 4 or less
  assign in_bounds = ((orient ? ye : xe) + le) <= 4'(BOARD_DIM);
  for (genvar c = 0; c < CELLS; c++) begin : g_cell
    localparam logic [3:0] CX = 4'(c % BOARD_DIM);
    localparam logic [3:0] CY = 4'(c / BOARD_DIM);
    assign mask[c] = orient ? (CX == xe && CY >= ye && CY < ye + le)
                            : (CY == ye && CX >= xe && CX < xe + le);
  end
endmodule

// File: rtl/colocador_barcos.sv
// colocador_barcos: interactive ship placement FSM on a 5x5 board.
// Define COLOCADOR_OVERLAP_CHK_EN to reject placements that overlap placed ships.
module colocador_barcos
  import colocador_pkg::*;
#(
  parameter int NUM_BARCOS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             rotate,
  input  logic             confirm,
  output logic [2:0]       cur_x,
  output logic [2:0]       cur_y,
  output logic             orient,
  output logic [2:0]       barco_idx,
  output logic             wr_en,
  output logic [2:0]       wr_barco,
  output logic [4:0]       wr_pos,
  output logic             wr_orient,
  output logic             err,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] ocupado
);
  localparam logic [2:0] MAXC = 3'(BOARD_DIM - 1);
  localparam logic [2:0] LAST = 3'(NUM_BARCOS - 1);
  estado_t state, state_d;
  logic [CELLS-1:0] mask;
  logic in_bounds, legal;
  logic [4:0] pos;
  mascara_barco u_mask (
    .x(cur_x), .y(cur_y), .orient(orient), .len(ship_len(barco_idx)),
    .mask(mask), .in_bounds(in_bounds)
  );
`ifdef COLOCADOR_OVERLAP_CHK_EN
  assign legal = in_bounds && ~|(mask & ocupado);
`else
  assign legal = in_bounds;
`endif
  assign pos = 5'(cur_y) * 5'(BOARD_DIM) + 5'(cur_x);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: state_d = start ? PLACE : state;
      PLACE:      state_d = confirm ? CHECK : PLACE;
      CHECK:      state_d = legal ? WRITE : PLACE;
      WRITE:      state_d = (barco_idx == LAST) ? DONE : PLACE;
      default:    state_d = IDLE;
    endcase
    busy = state == PLACE || state == CHECK || state == WRITE;
    done = state == DONE;
    wr_en = state == WRITE;
    err = state == CHECK && !legal;
    wr_barco = wr_en ? barco_idx : 3'd0;
    wr_pos = wr_en ? pos : 5'd0;
    wr_orient = wr_en & orient;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x <= '0;
      cur_y <= '0;
      orient <= 1'b0;
      barco_idx <= '0;
      ocupado <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          cur_x <= '0;
          cur_y <= '0;
          orient <= 1'b0;
          barco_idx <= '0;
          ocupado <= '0;
        end
        PLACE: if (!confirm) begin
          // one step per cycle, priority up > down > left > right
          if (up) cur_y <= (cur_y == 3'd0) ? 3'd0 : cur_y - 3'd1;
          else if (down) cur_y <= (cur_y == MAXC) ? MAXC : cur_y + 3'd1;
          else if (left) cur_x <= (cur_x == 3'd0) ? 3'd0 : cur_x - 3'd1;
          else if (right) cur_x <= (cur_x == MAXC) ? MAXC : cur_x + 3'd1;
          if (rotate) orient <= ~orient;
        end
        CHECK: if (legal) ocupado <= ocupado | mask;
        WRITE: if (barco_idx != LAST) begin
          barco_idx <= barco_idx + 3'd1;
          cur_x <= '0;
          cur_y <= '0;
          orient <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
